// File: rtl/led_seq_ctrl.sv
// Bus-mapped LED sequencer: static LED value plus a timed pattern table stepped by a prescaler.
// Single-cycle register writes; registered LED/SeqDone outputs; combinational read data.
module led_seq_ctrl #(
  parameter int NUM_STEPS = 4,
  parameter int PRESC_W   = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  output logic [15:0] DataRd,
  input  logic [15:0] DataWr,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  output logic [2:0]  LedGreen,
  output logic [2:0]  LedRed,
  output logic        SeqDone
);

  localparam int SW = $clog2(NUM_STEPS);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [5:0]           static_q, static_d;
  logic                 loop_q, loop_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
  logic [SW-1:0]        ptr_q, ptr_d;
  logic [SW-1:0]        step_q, step_d;
  logic [7:0]           dwell_cnt_q, dwell_cnt_d;
  logic [5:0]           led_q, led_d;
  logic                 done_q, done_d;
  logic [5:0]           tbl_led_q   [NUM_STEPS];
  logic [5:0]           tbl_led_d   [NUM_STEPS];
  logic [7:0]           tbl_dwell_q [NUM_STEPS];
  logic [7:0]           tbl_dwell_d [NUM_STEPS];

  logic                 wr_en;
  logic                 start;
  logic                 stop;
  logic [SW:0]          next_ext;
  logic [SW-1:0]        next_idx;
  logic                 unused_bits;

  assign wr_en       = Wr & En;
  assign unused_bits = Rd ^ (^DataWr[7:6]);
  assign next_ext    = {1'b0, step_q} + (SW+1)'(1);
  assign next_idx    = next_ext[SW-1:0];

  always_comb begin
    state_d     = state_q;
    static_d    = static_q;
    loop_d      = loop_q;
    presc_d     = presc_q;
    presc_cnt_d = presc_cnt_q;
    ptr_d       = ptr_q;
    step_d      = step_q;
    dwell_cnt_d = dwell_cnt_q;
    led_d       = led_q;
    done_d      = 1'b0;
    tbl_led_d   = tbl_led_q;
    tbl_dwell_d = tbl_dwell_q;
    start       = 1'b0;
    stop        = 1'b0;

    if (wr_en) begin
      case (Addr)
        2'd0: begin
          static_d = DataWr[13:8];
          loop_d   = DataWr[2];
          start    = DataWr[0];
          stop     = DataWr[1];
        end
        2'd1: presc_d = DataWr[PRESC_W-1:0];
        2'd2: ptr_d   = DataWr[SW-1:0];
        2'd3: begin
          tbl_led_d[ptr_q]   = DataWr[5:0];
          tbl_dwell_d[ptr_q] = DataWr[15:8];
          ptr_d              = ptr_q + SW'(1);
        end
      endcase
    end

    if (stop) begin
      state_d = IDLE;
      led_d   = static_d;
    end else if (start) begin
      if (tbl_dwell_q[0] == 8'd0) begin
        state_d = IDLE;
        led_d   = static_d;
      end else begin
        state_d     = RUN;
        step_d      = '0;
        dwell_cnt_d = tbl_dwell_q[0];
        presc_cnt_d = presc_q;
        led_d       = tbl_led_q[0];
      end
    end else if (state_q == RUN) begin
      // Prescaler free-runs across steps; only START reloads it out of turn.
      if (presc_cnt_q == '0) begin
        presc_cnt_d = presc_q;
        if (dwell_cnt_q > 8'd1) begin
          dwell_cnt_d = dwell_cnt_q - 8'd1;
        end else if (next_ext[SW] || tbl_dwell_q[next_idx] == 8'd0) begin
          if (loop_q && tbl_dwell_q[0] != 8'd0) begin
            step_d      = '0;
            dwell_cnt_d = tbl_dwell_q[0];
            led_d       = tbl_led_q[0];
          end else begin
            state_d = IDLE;
            led_d   = static_d;
            done_d  = 1'b1;
          end
        end else begin
          step_d      = next_idx;
          dwell_cnt_d = tbl_dwell_q[next_idx];
          led_d       = tbl_led_q[next_idx];
        end
      end else begin
        presc_cnt_d = presc_cnt_q - PRESC_W'(1);
      end
    end else begin
      led_d = static_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      static_q    <= '0;
      loop_q      <= 1'b0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      ptr_q       <= '0;
      step_q      <= '0;
      dwell_cnt_q <= '0;
      led_q       <= '0;
      done_q      <= 1'b0;
      tbl_led_q   <= '{default: '0};
      tbl_dwell_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      static_q    <= static_d;
      loop_q      <= loop_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      ptr_q       <= ptr_d;
      step_q      <= step_d;
      dwell_cnt_q <= dwell_cnt_d;
      led_q       <= led_d;
      done_q      <= done_d;
      tbl_led_q   <= tbl_led_d;
      tbl_dwell_q <= tbl_dwell_d;
    end
  end

  always_comb begin
    DataRd = '0;
    case (Addr)
      2'd0: begin
        DataRd[0]      = (state_q == RUN);
        DataRd[2]      = loop_q;
        DataRd[SW+3:4] = step_q;
        DataRd[13:8]   = static_q;
      end
      2'd1: DataRd[PRESC_W-1:0] = presc_q;
      2'd2: DataRd[SW-1:0]      = ptr_q;
      2'd3: begin
        DataRd[5:0]  = tbl_led_q[ptr_q];
        DataRd[15:8] = tbl_dwell_q[ptr_q];
      end
    endcase
  end

  assign LedGreen = led_q[2:0];
  assign LedRed   = led_q[5:3];
  assign SeqDone  = done_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed plan steps plus random tables
// compared against a per-cycle LED timeline built from the table contents.
module tb_led_seq_ctrl;

  localparam int NS = 4;

  logic        Clk;
  logic        Reset;
  logic [1:0]  Addr;
  logic [15:0] DataRd;
  logic [15:0] DataWr;
  logic        En;
  logic        Rd;
  logic        Wr;
  logic [2:0]  LedGreen;
  logic [2:0]  LedRed;
  logic        SeqDone;

  led_seq_ctrl #(.NUM_STEPS(NS), .PRESC_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataRd(DataRd), .DataWr(DataWr),
    .En(En), .Rd(Rd), .Wr(Wr), .LedGreen(LedGreen), .LedRed(LedRed), .SeqDone(SeqDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         step;
    logic [5:0] led;
  } exp_t;

  int         errors = 0;
  int         checks = 0;
  exp_t       exp_q[$];
  logic [5:0] m_led   [NS];
  int         m_dwell [NS];
  int         m_presc;
  logic [5:0] m_static;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
    tick();
    Wr = 1'b0; En = 1'b0; Addr = 2'd0; DataWr = '0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
    Addr = a; En = 1'b1; Rd = 1'b1;
    #1;
    d = DataRd;
    Rd = 1'b0; En = 1'b0; Addr = 2'd0;
  endtask

  task automatic write_entry(input int idx, input logic [5:0] led, input int dwell);
    bus_wr(2'd2, 16'(idx));
    bus_wr(2'd3, {8'(dwell), 2'b00, led});
    m_led[idx]   = led;
    m_dwell[idx] = dwell;
  endtask

  // Expected timeline: each step s with nonzero dwell is shown dwell*(presc+1) cycles.
  task automatic build_seq(input int passes);
    exp_q.delete();
    if (m_dwell[0] != 0) begin
      for (int p = 0; p < passes; p++)
        for (int s = 0; s < NS && m_dwell[s] != 0; s++)
          for (int c = 0; c < m_dwell[s] * (m_presc + 1); c++)
            exp_q.push_back('{s, m_led[s]});
    end
  endtask

  task automatic chk_state(input string tag, input logic [5:0] led, input int step,
                           input logic busy, input logic done);
    logic [15:0] r;
    bus_rd(2'd0, r);
    chk({tag, "/led"}, 16'({LedRed, LedGreen}), 16'(led));
    chk({tag, "/done"}, 16'(SeqDone), 16'(done));
    chk({tag, "/busy"}, 16'(r[0]), 16'(busy));
    if (busy) chk({tag, "/step"}, 16'(r[5:4]), 16'(step));
  endtask

  task automatic check_run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk_state(tag, exp_q[i].led, exp_q[i].step, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic check_end(input string tag, input logic done_exp);
    chk_state({tag, "_end"}, m_static, 0, 1'b0, done_exp);
    tick();
    chk_state({tag, "_after"}, m_static, 0, 1'b0, 1'b0);
  endtask

  task automatic start_seq(input logic loop_en);
    bus_wr(2'd0, {2'b00, m_static, 5'b0, loop_en, 2'b01});
  endtask

  initial begin
    logic [15:0] r;
    Reset = 1'b0; Addr = 2'd0; DataWr = '0; En = 1'b0; Rd = 1'b0; Wr = 1'b0;
    for (int i = 0; i < NS; i++) begin m_led[i] = '0; m_dwell[i] = 0; end
    m_presc = 0; m_static = '0;
    #12 Reset = 1'b1;
    tick();

    // 1: reset state and static LEDs
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), r);
      chk($sformatf("rst_rd%0d", a), r, 16'h0000);
    end
    chk("rst_led", 16'({LedRed, LedGreen}), 16'h0000);
    chk("rst_done", 16'(SeqDone), 16'h0000);
    m_static = 6'b101010;
    bus_wr(2'd0, {2'b00, m_static, 8'h00});
    chk("static_red", 16'(LedRed), 16'h0005);
    chk("static_green", 16'(LedGreen), 16'h0002);
    bus_rd(2'd0, r);
    chk("static_rd", r, 16'h2A00);

    // 2: two-step one-shot sequence
    m_presc = 3;
    bus_wr(2'd1, 16'(m_presc));
    write_entry(0, 6'h01, 2);
    write_entry(1, 6'h04, 1);
    write_entry(2, 6'h00, 0);
    bus_rd(2'd2, r);
    chk("ptr_after_entry", r, 16'h0003);
    start_seq(1'b0);
    build_seq(1);
    chk("seq2_len", 16'(exp_q.size()), 16'd12);
    check_run("seq2", exp_q.size());
    check_end("seq2", 1'b1);

    // 3: looping, then STOP mid-step
    start_seq(1'b1);
    build_seq(3);
    check_run("loop3", 27);
    bus_wr(2'd0, {2'b00, m_static, 8'h02});
    check_end("stop3", 1'b0);

    // 4: one-cycle steps filling the whole table
    m_presc = 0;
    bus_wr(2'd1, 16'h0000);
    for (int i = 0; i < NS; i++) write_entry(i, 6'(1 << i), 1);
    start_seq(1'b0);
    build_seq(1);
    check_run("wrap4", exp_q.size());
    check_end("wrap4", 1'b1);

    // 5: START|STOP in IDLE, and START with zero first dwell
    bus_wr(2'd0, {2'b00, m_static, 8'h03});
    chk_state("startstop5", m_static, 0, 1'b0, 1'b0);
    write_entry(0, 6'h11, 0);
    start_seq(1'b0);
    chk_state("zerodwell5", m_static, 0, 1'b0, 1'b0);

    // random tables and prescalers, one-shot
    for (int t = 0; t < 8; t++) begin
      m_presc  = $urandom_range(0, 3);
      m_static = 6'($urandom_range(0, 63));
      bus_wr(2'd1, 16'(m_presc));
      for (int i = 0; i < NS; i++)
        write_entry(i, 6'($urandom_range(0, 63)), (t == 0 && i == 0) ? 0 : $urandom_range(0, 3));
      start_seq(1'b0);
      build_seq(1);
      check_run($sformatf("rnd%0d", t), exp_q.size());
      check_end($sformatf("rnd%0d", t), exp_q.size() > 0);
    end

    // 6: asynchronous reset mid-run
    m_presc = 3;
    bus_wr(2'd1, 16'h0003);
    write_entry(0, 6'h3F, 4);
    start_seq(1'b0);
    tick(); tick(); tick();
    #2 Reset = 1'b0;
    #1;
    chk("arst_led", 16'({LedRed, LedGreen}), 16'h0000);
    bus_rd(2'd0, r);
    chk("arst_busy", 16'(r[0]), 16'h0000);
    chk("arst_done", 16'(SeqDone), 16'h0000);
    #2 Reset = 1'b1;
    tick();
    for (int a = 0; a < 3; a++) begin
      bus_rd(2'(a), r);
      chk($sformatf("post_rst_rd%0d", a), r, 16'h0000);
    end
    for (int i = 0; i < NS; i++) begin
      bus_wr(2'd2, 16'(i));
      bus_rd(2'd3, r);
      chk($sformatf("post_rst_entry%0d", i), r, 16'h0000);
    end
    chk("post_rst_led", 16'({LedRed, LedGreen}), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Bus-mapped sequencer that owns the board's 3 green and 3 red status LEDs.
- Holds a static LED value and a table of NUM_STEPS timed LED patterns.
- On command it steps through the pattern table using a programmable prescaler, once or looping, then falls back to the static value.
- Sits on the same 16-bit peripheral bus as the other small controllers, behind a chip-select (En).

Parameters:
- NUM_STEPS, 4: pattern table depth; must be a power of 2, ≥2; step index width SW = log2(NUM_STEPS).
- PRESC_W, 16: prescaler width, ≤16.

Ports:
- Clk  in  1  system clock; all state on posedge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Addr  in  2  register select.
- DataRd  out  16  read data.
- DataWr  in  16  write data.
- En  in  1  block select.
- Rd  in  1  read strobe; no side effects.
- Wr  in  1  write strobe; a write occurs on a Clk edge with Wr & En = 1.
- LedGreen  out  3  green LED drive, registered.
- LedRed  out  3  red LED drive, registered.
- SeqDone  out  1  one-cycle pulse when a non-looping sequence completes.

Behaviour:
- Register map:
  - Addr 0 CTRL.
    - Write: [0] START, [1] STOP, [2] LOOP (stored), [13:8] STATIC {R[2:0],G[2:0]} (stored).
    - Read: [0] BUSY, [2] LOOP, [SW+3:4] current step, [13:8] STATIC, other bits 0.
  - Addr 1 PRESC.
    - Write/read [PRESC_W-1:0]; one tick every PRESC+1 Clk cycles.
  - Addr 2 INDEX.
    - Write/read table pointer [SW-1:0].
  - Addr 3 ENTRY.
    - Write stores DataWr into entry[ptr]: [5:0] LEDs {R,G}, [15:8] DWELL in ticks.
    - Then ptr <= ptr+1 mod NUM_STEPS.
    - Read returns entry[ptr] with [7:6] = 0.
- DataRd is combinational from Addr and state, defined for all four addresses. Unused bits read 0, never X.
- Reset (async, Reset=0):
  - State IDLE, LedGreen=LedRed=0, SeqDone=0.
  - STATIC=0, LOOP=0, PRESC=0, ptr=0, step=0.
  - All table entries 0.
- States: IDLE, RUN.
  - IDLE: LEDs follow STATIC one cycle after a write.
  - START in IDLE or RUN:
    - If entry[0].DWELL = 0, stay/go IDLE.
    - Otherwise: step=0, dwell counter = entry[0].DWELL, prescaler counter = PRESC, LEDs = entry[0].LEDs on the next edge, state RUN.
  - STOP:
    - Go to IDLE next edge; LEDs = STATIC; no SeqDone.
    - STOP and START in the same write: STOP wins.
- RUN timing:
  - Prescaler counts down each Clk. At 0 it generates a tick and reloads from the current PRESC; a PRESC write takes effect at the next reload.
  - On tick:
    - If dwell counter > 1, decrement.
    - Otherwise advance to next = step+1.
  - On advance, if next = NUM_STEPS or entry[next].DWELL = 0, the end is reached:
    - LOOP=1 and entry[0].DWELL ≠ 0: restart at step 0.
    - Otherwise: IDLE, LEDs = STATIC, SeqDone = 1 for one cycle.
  - On a normal advance, LEDs and dwell counter load from entry[next].
  - Step s is shown for exactly DWELL_s × (PRESC+1) Clk cycles. The prescaler is not cleared between steps.
- Table writes during RUN are allowed.
  - Entries are sampled only when their step is loaded.
  - Rewriting the current step does not alter its LEDs or remaining dwell.
- A STATIC write during RUN is stored; it has no LED effect until IDLE.
- BUSY = (state == RUN).
- Reset asserted mid-RUN: immediate return to reset values, LEDs 0.

Test Plan:
1. Reset, then read Addr 0..3: all read 0, LEDs 0; write CTRL STATIC=6'b101010 → LedRed=3'b101, LedGreen=3'b010 one cycle later.
2. Program PRESC=3, INDEX=0, ENTRY=0x0201, 0x0104, then 0x0000; START → LEDs {R,G}=6'h01 for 8 cycles, 6'h04 for 4 cycles, then STATIC, SeqDone pulses once, BUSY=0.
3. Same table with LOOP=1: the pattern repeats 01,04,01,04 with exact 8/4-cycle periods; STOP mid-step → STATIC next cycle, no SeqDone.
4. All 4 entries non-zero (DWELL 1,1,1,1), PRESC=0, LOOP=0 → steps 0–3 one cycle each, end at step wrap, SeqDone asserted.
5. Write CTRL with START|STOP while IDLE → remains IDLE; START with entry[0].DWELL=0 → BUSY stays 0.
6. Drive Reset low mid-RUN (asynchronously, between clock edges) → LEDs 0 immediately, BUSY=0; table reads back 0 after release.
